// File: rtl/alu_logic_arbiter_if.sv
// Request/response bundle between the two requesters and the shared ALU logic arbiter.
// A transfer happens on any rising edge where valid && ready are both high; valid never waits on ready.
interface alu_logic_arbiter_if #(
  parameter int WIDTH = 20
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_result, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter sharing one NOT/AND/OR/XOR unit between two requesters.
// One op in flight: IDLE (grant/accept) -> EXEC (evaluate) -> RESP (hold until owner accepts).
module alu_logic_arbiter #(
  parameter int WIDTH     = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_logic_arbiter_if.slave   bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant;
  logic             owner_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic             gnt_valid;
  logic             gnt_id;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] alu_f;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last_grant;
    end else if (bus.req0_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b0;
    end else if (bus.req1_valid) begin
      gnt_valid = 1'b1;
      gnt_id    = 1'b1;
    end
  end

  always_comb begin
    alu_f = '0;
    case (op_q)
      2'b00:   alu_f = ~a_q;
      2'b01:   alu_f = a_q & b_q;
      2'b10:   alu_f = a_q | b_q;
      default: alu_f = a_q ^ b_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_done = 1'b0;
    case (state_q)
      IDLE: begin
        accept = gnt_valid;
        if (gnt_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        rsp_done = bus.rsp_ready[owner_q];
        if (rsp_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated with rst_n so nothing is accepted while reset is held.
  assign bus.req0_ready = rst_n && accept && !gnt_id;
  assign bus.req1_ready = rst_n && accept &&  gnt_id;
  assign bus.rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state      = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_grant <= 1'b1;
      owner_q    <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      op_count   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt_id;
        op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
        a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
      end
      if (state_q == EXEC) begin
        result_q <= alu_f;
        zero_q   <= (alu_f == '0);
      end
      if (rsp_done) begin
        last_grant <= owner_q;
        op_count   <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed-vector bench for alu_logic_arbiter; counter width shrunk to 4 to reach wrap quickly.
module tb_alu_logic_arbiter;
  localparam int WIDTH     = 20;
  localparam int CNT_WIDTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 busy;
  logic [CNT_WIDTH-1:0] op_count;
  logic [1:0]           dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  logic [CNT_WIDTH-1:0] exp_count = '0;

  alu_logic_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_logic_arbiter #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .op_count  (op_count),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 2'b00;
  endtask

  // Called just after a falling edge with the DUT idle; returns just after a falling edge, idle again.
  task automatic do_op(input int r, input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp);
    logic [1:0] own;
    own = (r == 0) ? 2'b01 : 2'b10;
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1 chk("accept_ready", {bus.req1_ready, bus.req0_ready}, own);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = ~a; bus.req0_b = ~b; bus.req1_a = ~a; bus.req1_b = ~b;
    chk("exec_busy", busy, 1);
    chk("exec_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("resp_valid", bus.rsp_valid, own);
    chk("resp_result", bus.rsp_result, exp);
    chk("resp_zero", bus.rsp_zero, (exp == '0));
    bus.rsp_ready = own;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    exp_count = exp_count + 1'b1;
    chk("done_count", op_count, exp_count);
    chk("done_busy", busy, 0);
    chk("done_rsp_valid", bus.rsp_valid, 0);
    chk("done_result_held", bus.rsp_result, exp);
  endtask

  initial begin
    logic [1:0] er;
    rst_n = 1'b0;
    idle_inputs();
    bus.req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_result", bus.rsp_result, 0);
    chk("rst_zero", bus.rsp_zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_state", dbg_state, 0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    do_op(0, 2'b00, 20'h152AA, 20'h00000, 20'hEAD55);
    do_op(1, 2'b01, 20'hFFFFF, 20'h0F0F0, 20'h0F0F0);
    do_op(1, 2'b11, 20'h3C3C3, 20'h3C3C3, 20'h00000);

    // Round-robin from reset with both requesters continuously valid.
    rst_n = 1'b0;
    #1 chk("rr_rst_count", op_count, 0);
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = 2'b10; bus.req0_a = 20'h00F00; bus.req0_b = 20'h000FF;
    bus.req1_valid = 1'b1; bus.req1_op = 2'b00; bus.req1_a = 20'h00000; bus.req1_b = 20'h00000;
    bus.rsp_ready  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      er = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("rr_ready", {bus.req1_ready, bus.req0_ready}, er);
      @(negedge clk);
      chk("rr_exec_ready", {bus.req1_ready, bus.req0_ready}, 0);
      @(negedge clk);
      chk("rr_rsp_valid", bus.rsp_valid, er);
      chk("rr_result", bus.rsp_result, (k % 2 == 0) ? 20'h00FFF : 20'hFFFFF);
      @(negedge clk);
      exp_count = exp_count + 1'b1;
    end
    idle_inputs();
    chk("rr_count", op_count, exp_count);

    // Backpressure: response held, new request and non-owner ready ignored.
    bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 20'hFFFFF; bus.req0_b = 20'h12345;
    #1 chk("bp_accept", bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_a = 20'h00000;
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_result", bus.rsp_result, 20'h12345);
      chk("bp_busy", busy, 1);
      chk("bp_no_ready", bus.req0_ready, 0);
      @(negedge clk);
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 2'b01;
    @(negedge clk);
    bus.rsp_ready  = 2'b00;
    exp_count = exp_count + 1'b1;
    chk("bp_count", op_count, exp_count);
    chk("bp_idle", dbg_state, 0);

    // Reset during EXEC aborts the op; pending requester is granted again afterwards.
    bus.req1_valid = 1'b1; bus.req1_op = 2'b10; bus.req1_a = 20'h0000F; bus.req1_b = 20'h000F0;
    #1 chk("mid_accept", bus.req1_ready, 1);
    @(negedge clk);
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", {bus.req1_ready, bus.req0_ready}, 0);
    chk("mid_count", op_count, 0);
    chk("mid_result", bus.rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = '0;
    #1 chk("mid_regrant", {bus.req1_ready, bus.req0_ready}, 2'b10);
    chk("mid_state", dbg_state, 0);
    bus.req1_valid = 1'b0;
    @(negedge clk);

    // Sixteen NOT ops wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] av;
      av = 20'h01000 * i[WIDTH-1:0] + 20'h00055;
      do_op(i % 2, 2'b00, av, 20'h00000, ~av);
    end
    chk("wrap_count", op_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_logic_arbiter.md
Name: alu_logic_arbiter

Overview:
- Sequencer and arbiter that shares one WIDTH-bit ALU logic unit (NOT/AND/OR/XOR) between two requesters, e.g. decode/issue and the microcode path.
- Accepts one operation at a time over a valid/ready handshake and latches the operands.
- Evaluates the operation and holds a registered result until the owning requester accepts it.
- Grants round-robin on contention. Sits between the control unit and the ALU logic sub-blocks.

Parameters:
- WIDTH, 20, operand/result width in bits.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 handshake accepted this cycle.
- req0_op  input  2  opcode: 00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B; ignored for NOT.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0.
- rsp_valid  output  2  bit i: result for requester i is valid.
- rsp_ready  input  2  bit i: requester i accepts its result.
- rsp_result  output  WIDTH  registered result.
- rsp_zero  output  1  high when rsp_result == 0.
- busy  output  1  high whenever state != IDLE.
- op_count  output  CNT_WIDTH  count of completed responses.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (requester 0 wins the first tie).
  - rsp_valid=0, rsp_result=0, rsp_zero=0, busy=0, op_count=0.
  - Latched op/operands/owner id cleared.
  - reqX_ready=0 while in reset.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only req0_valid asserted → grant 0. Only req1_valid asserted → grant 1. Both asserted → grant !last_grant. Neither asserted → no grant.
  - reqX_ready=1 only for the granted requester and only in IDLE. The ungranted ready stays 0.
  - On valid&&ready: latch op, a, b and owner id; next state EXEC.
- EXEC (one cycle):
  - rsp_result <= f(op, a, b), full WIDTH.
  - NOT inverts all WIDTH bits; no carry and no extension.
  - rsp_zero <= (f == 0).
  - Next state RESP.
- RESP:
  - rsp_valid[owner]=1; the other bit stays 0.
  - rsp_result and rsp_zero are held stable.
  - When rsp_ready[owner]=1: next state IDLE, last_grant <= owner, op_count <= op_count+1 (wraps modulo 2^CNT_WIDTH).
  - rsp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Handshake in cycle N → rsp_valid high in cycle N+2.
  - Earliest next acceptance is the cycle after the response handshake. Peak throughput is 1 op / 3 cycles.
- Boundary rules:
  - Requests arriving in EXEC or RESP are not accepted. They must stay valid; no ready is given.
  - Requester may drop valid before ready with no effect.
  - Requester's inputs may change after the accept handshake without affecting the result.
  - rsp_ready held high continuously: response completes in its first RESP cycle.
  - Reset asserted mid-operation aborts it. No response is issued and op_count is not incremented.
  - Illegal states recover to IDLE.
  - rsp_result keeps its last value in IDLE; only rsp_valid qualifies it.

Test Plan:
- NOT: reset, req0 op=00 a=20'h152AA → req0_ready pulse, rsp_valid=2'b01 two cycles later, rsp_result=20'hEAD55, rsp_zero=0, op_count=1.
- AND/XOR:
  - req1 op=01 a=20'hFFFFF b=20'h0F0F0 → rsp_valid=2'b10, rsp_result=20'h0F0F0.
  - Then req1 op=11 a=b=20'h3C3C3 → rsp_result=0, rsp_zero=1.
- Tie/round-robin: from reset, both valid continuously (req0 OR 20'h00F00|20'h000FF, req1 NOT 20'h00000) → order req0 (20'h00FFF), req1 (20'hFFFFF), req0, req1. Never two ready high at once.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_result stable; req0_valid during this window gets no ready; busy=1 throughout.
- Reset mid-op: assert rst_n=0 during EXEC → all outputs 0 immediately. After release, state IDLE, op_count=0, and the pending requester is re-granted.
- Counter wrap: CNT_WIDTH=4, complete 16 NOT ops → op_count returns to 0 after the 16th response.
